// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: instruction, SRAM, PE and result signals of the serial_pe sequencer
interface pe_seq_ctrl_if #(
  parameter int LINE_W = 512,
  parameter int ELEM_W = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 8
);
  logic              inst_vld;
  logic              inst_rdy;
  logic [LEN_W-1:0]  inst_len;
  logic [ADDR_W-1:0] inst_nbase;
  logic [ADDR_W-1:0] inst_wbase;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_naddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [LINE_W-1:0] mem_ndata;
  logic [LINE_W-1:0] mem_wdata;
  logic [ELEM_W-1:0] pe_neuron;
  logic [ELEM_W-1:0] pe_weight;
  logic [1:0]        pe_ctl;
  logic              pe_vld_i;
  logic [ACC_W-1:0]  pe_result;
  logic              pe_vld_o;
  logic              res_vld;
  logic [ACC_W-1:0]  res_data;
  logic [7:0]        res_tag;
  logic              idle;
  logic              err_len0;
  modport master (
    input  inst_vld, inst_len, inst_nbase, inst_wbase, mem_ndata, mem_wdata, pe_result, pe_vld_o,
    output inst_rdy, mem_rd, mem_naddr, mem_waddr, pe_neuron, pe_weight, pe_ctl, pe_vld_i,
           res_vld, res_data, res_tag, idle, err_len0
  );
  modport slave (
    output inst_vld, inst_len, inst_nbase, inst_wbase, mem_ndata, mem_wdata, pe_result, pe_vld_o,
    input  inst_rdy, mem_rd, mem_naddr, mem_waddr, pe_neuron, pe_weight, pe_ctl, pe_vld_i,
           res_vld, res_data, res_tag, idle, err_len0
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: dot-product sequencer feeding serial_pe; PE_SEQ_CTRL_PERF_EN adds perf counters
module pe_seq_ctrl #(
  parameter int LINE_W = 512,
  parameter int ELEM_W = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef PE_SEQ_CTRL_PERF_EN
  output logic [31:0] perf_busy,
  output logic [15:0] perf_insts,
`endif
  pe_seq_ctrl_if.master bus
);
  localparam int EPL = LINE_W / ELEM_W;
  localparam int EW = $clog2(EPL);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STREAM} state_t;
  state_t state, nxt;
  logic [LEN_W-1:0] len, line_cnt;
  logic [EW-1:0] elem_cnt;
  logic [ADDR_W-1:0] nbase, wbase, off;
  logic [LINE_W-1:0] nsh, wsh;
  logic [ACC_W-1:0] res_q;
  logic [7:0] ret_tag;
  logic [8:0] outst;
  logic accept, first, last, pf, rd;
  always_comb begin
    accept = state == IDLE && bus.inst_vld && bus.inst_len != '0;
    first = state == STREAM && line_cnt == '0 && elem_cnt == '0;
    last = state == STREAM && line_cnt == len - LEN_W'(1) && elem_cnt == EW'(EPL - 1);
    pf = state == STREAM && elem_cnt == EW'(EPL - 2) && line_cnt < len - LEN_W'(1);
    rd = state == FETCH || pf;
    off = state == FETCH ? '0 : ADDR_W'(line_cnt) + ADDR_W'(1);
    nxt = state == IDLE ? (accept ? FETCH : IDLE) :
          state == FETCH ? LOAD :
          state == LOAD ? STREAM :
          (last ? IDLE : STREAM);
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  assign bus.inst_rdy = state == IDLE;
  assign bus.mem_rd = rd;
  assign bus.mem_naddr = rd ? nbase + off : '0;
  assign bus.mem_waddr = rd ? wbase + off : '0;
  assign bus.pe_neuron = nsh[LINE_W-1 -: ELEM_W];
  assign bus.pe_weight = wsh[LINE_W-1 -: ELEM_W];
  assign bus.pe_ctl = {last, first};
  assign bus.pe_vld_i = state == STREAM;
  assign bus.idle = state == IDLE && outst == '0;
  assign bus.res_data = res_q;
  // Prefetched line lands exactly as the last element of the current line drains
  always_ff @(posedge clk)
    if (!rst_n) begin
      len <= '0;
      line_cnt <= '0;
      elem_cnt <= '0;
      nbase <= '0;
      wbase <= '0;
      nsh <= '0;
      wsh <= '0;
    end else begin
      if (accept) begin
        len <= bus.inst_len;
        nbase <= bus.inst_nbase;
        wbase <= bus.inst_wbase;
        line_cnt <= '0;
      end
      if (state == LOAD) begin
        nsh <= bus.mem_ndata;
        wsh <= bus.mem_wdata;
        elem_cnt <= '0;
      end else if (state == STREAM) begin
        elem_cnt <= elem_cnt + EW'(1);
        nsh <= elem_cnt == EW'(EPL - 1) ? bus.mem_ndata : {nsh[LINE_W-ELEM_W-1:0], {ELEM_W{1'b0}}};
        wsh <= elem_cnt == EW'(EPL - 1) ? bus.mem_wdata : {wsh[LINE_W-ELEM_W-1:0], {ELEM_W{1'b0}}};
        if (elem_cnt == EW'(EPL - 1)) line_cnt <= line_cnt + LEN_W'(1);
      end
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      bus.err_len0 <= 1'b0;
      bus.res_vld <= 1'b0;
      bus.res_tag <= '0;
      res_q <= '0;
      ret_tag <= '0;
      outst <= '0;
    end else begin
      bus.err_len0 <= state == IDLE && bus.inst_vld && bus.inst_len == '0;
      bus.res_vld <= bus.pe_vld_o;
      if (bus.pe_vld_o) begin
        res_q <= bus.pe_result;
        bus.res_tag <= ret_tag;
        ret_tag <= ret_tag + 8'd1;
      end
      outst <= accept && !bus.pe_vld_o ? outst + 9'd1 :
               !accept && bus.pe_vld_o && outst != '0 ? outst - 9'd1 : outst;
    end
`ifdef PE_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      perf_busy <= '0;
      perf_insts <= '0;
    end else begin
      if (state == STREAM && !(&perf_busy)) perf_busy <= perf_busy + 32'd1;
      if (accept && !(&perf_insts)) perf_insts <= perf_insts + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: randomized directed bench with SRAM/PE models and a stream-level reference
module tb_pe_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  pe_seq_ctrl_if bus ();
`ifdef PE_SEQ_CTRL_PERF_EN
  logic [31:0] perf_busy;
  logic [15:0] perf_insts;
`endif
  pe_seq_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PE_SEQ_CTRL_PERF_EN
    .perf_busy(perf_busy),
    .perf_insts(perf_insts),
`endif
    .bus(bus)
  );
  typedef struct { logic [15:0] n; logic [15:0] w; logic [1:0] ctl; bit pf; } el_t;
  typedef struct { logic [10:0] na; logic [10:0] wa; } ad_t;
  typedef struct { logic [31:0] d; logic [7:0] t; } rs_t;
  typedef struct { int due; logic [31:0] v; } pd_t;
  logic [511:0] nmem [2048];
  logic [511:0] wmem [2048];
  el_t sq[$];
  ad_t aq[$];
  rs_t rq[$];
  pd_t pq[$];
  int vectors = 0, fails = 0, cyc = 0;
  int vld_from = 0, rdy_from = 0, fetch_at = -1, err_at = -1, model_out = 0;
  int rd_cnt = 0, err_cnt = 0, inj_cnt = 0, inj_done = 0, last_due = -1;
  logic [7:0] tag_model = 8'd0, last_tag = 8'd0;
  logic [31:0] last_data = 32'd0, acc = 32'd0, inj_val = 32'hDEAD_BEEF;
  el_t e;
  ad_t a;
  rs_t r;
  bit exp_vld, pf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk)
    if (bus.mem_rd === 1'b1) begin
      bus.mem_ndata <= nmem[bus.mem_naddr];
      bus.mem_wdata <= wmem[bus.mem_waddr];
    end

  always @(negedge clk) begin
    cyc++;
    exp_vld = cyc >= vld_from && cyc < rdy_from;
    chk("pe_vld_i", bus.pe_vld_i, exp_vld);
    chk("inst_rdy", bus.inst_rdy, cyc >= rdy_from);
    chk("err_len0", bus.err_len0, cyc == err_at);
    if (bus.err_len0 === 1'b1) err_cnt++;
    pf = 1'b0;
    if (exp_vld) begin
      if (sq.size() == 0) chk("stream_underrun", 0, 1);
      else begin
        e = sq.pop_front();
        chk("pe_neuron", bus.pe_neuron, e.n);
        chk("pe_weight", bus.pe_weight, e.w);
        chk("pe_ctl", bus.pe_ctl, e.ctl);
        pf = e.pf;
      end
    end else chk("pe_ctl_quiet", bus.pe_ctl, 0);
    chk("mem_rd", bus.mem_rd, cyc == fetch_at || pf);
    if (bus.mem_rd === 1'b1) begin
      rd_cnt++;
      if (aq.size() == 0) chk("addr_underrun", 0, 1);
      else begin
        a = aq.pop_front();
        chk("mem_naddr", bus.mem_naddr, a.na);
        chk("mem_waddr", bus.mem_waddr, a.wa);
      end
    end
    if (bus.res_vld === 1'b1) begin
      if (model_out > 0) model_out--;
      last_data = bus.res_data;
      last_tag = bus.res_tag;
      if (rq.size() == 0) chk("res_unexpected", 0, 1);
      else begin
        r = rq.pop_front();
        chk("res_data", bus.res_data, r.d);
        chk("res_tag", bus.res_tag, r.t);
      end
    end
    chk("idle", bus.idle, cyc >= rdy_from && model_out == 0);
    // PE model: accumulate what the DUT streams, return results in order
    if (bus.pe_vld_i === 1'b1) begin
      acc = (bus.pe_ctl[0] ? 32'd0 : acc) + 32'(bus.pe_neuron) * 32'(bus.pe_weight);
      if (bus.pe_ctl[1]) begin
        last_due = (cyc + int'($urandom_range(0, 3)) > last_due) ? cyc + int'($urandom_range(0, 3)) : last_due + 1;
        pq.push_back('{last_due, acc});
      end
    end
    bus.pe_vld_o = 1'b0;
    if (pq.size() != 0 && pq[0].due <= cyc) begin
      bus.pe_vld_o = 1'b1;
      bus.pe_result = pq[0].v;
      void'(pq.pop_front());
    end else if (pq.size() == 0 && inj_done < inj_cnt) begin
      bus.pe_vld_o = 1'b1;
      bus.pe_result = inj_val;
      inj_done++;
    end
  end

  task automatic issue(input int len, input logic [10:0] nb, input logic [10:0] wb);
    bit ok = 1'b0;
    logic [31:0] s = 32'd0;
    logic [10:0] na, wa;
    logic [15:0] n, w;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      #1;
      ok = cyc >= rdy_from;
    end
    if (!ok) chk("rdy_timeout", 0, 1);
    bus.inst_vld = 1'b1;
    bus.inst_len = 8'(len);
    bus.inst_nbase = nb;
    bus.inst_wbase = wb;
    @(posedge clk);
    #1;
    bus.inst_vld = 1'b0;
    if (len == 0) err_at = cyc + 1;
    else begin
      for (int l = 0; l < len; l++) begin
        na = nb + 11'(l);
        wa = wb + 11'(l);
        aq.push_back('{na, wa});
        for (int k = 0; k < 32; k++) begin
          n = nmem[na][511 - 16 * k -: 16];
          w = wmem[wa][511 - 16 * k -: 16];
          s = s + 32'(n) * 32'(w);
          sq.push_back('{n, w, {l == len - 1 && k == 31, l == 0 && k == 0}, k == 30 && l < len - 1});
        end
      end
      rq.push_back('{s, tag_model});
      tag_model++;
      model_out++;
      fetch_at = cyc + 1;
      vld_from = cyc + 3;
      rdy_from = cyc + 3 + 32 * len;
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      #1;
      ok = rq.size() == 0 && cyc >= rdy_from;
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 2048; i++)
      for (int k = 0; k < 16; k++) begin
        nmem[i][32 * k +: 32] = $urandom;
        wmem[i][32 * k +: 32] = $urandom;
      end
    for (int k = 0; k < 32; k++) begin
      nmem[0][511 - 16 * k -: 16] = 16'(k + 1);
      wmem[0][511 - 16 * k -: 16] = 16'd1;
    end
    rst_n = 1'b0;
    bus.inst_vld = 1'b0;
    bus.inst_len = '0;
    bus.inst_nbase = '0;
    bus.inst_wbase = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_inst_rdy", bus.inst_rdy, 1);
    chk("rst_idle", bus.idle, 1);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_naddr", bus.mem_naddr, 0);
    chk("rst_pe_vld_i", bus.pe_vld_i, 0);
    chk("rst_pe_neuron", bus.pe_neuron, 0);
    chk("rst_res_vld", bus.res_vld, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_err_len0", bus.err_len0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // len=0 is dropped without fetch or tag
    r0 = rd_cnt;
    issue(0, 11'h123, 11'h456);
    repeat (4) @(negedge clk);
    #1;
    chk("len0_err_pulses", err_cnt, 1);
    chk("len0_no_rd", rd_cnt - r0, 0);
    r0 = rd_cnt;
    issue(1, 11'h000, 11'h000);
    wait_drain();
    chk("t1_result", last_data, 528);
    chk("t1_tag", last_tag, 0);
    chk("t1_rd_count", rd_cnt - r0, 1);
    r0 = rd_cnt;
    issue(4, 11'h010, 11'($urandom));
    wait_drain();
    chk("t2_rd_count", rd_cnt - r0, 4);
    chk("t2_tag", last_tag, 1);
    for (int i = 1; i <= 4; i++) issue(i, 11'($urandom), 11'($urandom));
    wait_drain();
    chk("b2b_last_tag", last_tag, 5);
    issue(2, 11'h7FF, 11'h7FE);
    wait_drain();
    for (int i = 0; i < 8; i++) issue(int'($urandom_range(0, 3)), 11'($urandom), 11'($urandom));
    wait_drain();
    // abort a len=3 instruction on element 40
    issue(3, 11'($urandom), 11'($urandom));
    repeat (43) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sq.delete();
    aq.delete();
    rq.delete();
    tag_model = 8'd0;
    model_out = 0;
    rdy_from = 0;
    vld_from = 0;
    fetch_at = -1;
    err_at = -1;
    @(negedge clk);
    #1;
    chk("abort_pe_vld_i", bus.pe_vld_i, 0);
    chk("abort_inst_rdy", bus.inst_rdy, 1);
    chk("abort_idle", bus.idle, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(2, 11'($urandom), 11'($urandom));
    wait_drain();
    chk("reissue_tag", last_tag, 0);
    rq.push_back('{inj_val, tag_model});
    inj_cnt++;
    wait_drain();
    chk("spurious_data", last_data, inj_val);
    chk("spurious_tag", last_tag, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("spurious_idle", bus.idle, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
